// File: rtl/stat_pkg.sv
// Shared types for the statistics snapshot path: per-channel entry,
// drain FSM states and the drop counter width.
package stat_pkg;

    localparam int STAT_IDX_W = 4;
    localparam int STAT_VAL_W = 32;
    localparam int DROP_W     = 16;

    typedef struct packed {
        logic [STAT_IDX_W-1:0] index;
        logic [STAT_VAL_W-1:0] value;
    } stat_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } stat_state_e;

endpackage

// File: rtl/stat_next_chan.sv
// Finds the lowest channel at or above start_i whose index is non-zero.
// Ports: idx_i (packed per-channel indices), start_i (CH_W+1 bits so that
// NUM means "past the end"), chan_o (channel found), found_o (hit flag).
module stat_next_chan #(
    parameter int IDX_W = 4,
    parameter int NUM   = 16,
    parameter int CH_W  = $clog2(NUM)
) (
    input  logic [NUM*IDX_W-1:0] idx_i,
    input  logic [CH_W:0]        start_i,
    output logic [CH_W-1:0]      chan_o,
    output logic                 found_o
);

    // Scan downward so the lowest qualifying channel is the final write.
    always_comb begin
        chan_o  = '0;
        found_o = 1'b0;
        for (int c = NUM - 1; c >= 0; c--) begin
            if (((CH_W+1)'(c) >= start_i) &&
                (idx_i[c*IDX_W +: IDX_W] != '0)) begin
                chan_o  = CH_W'(c);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stat_snapshot_queue.sv
// DEPTH-entry snapshot FIFO of NUM (index,value) pairs, drained one channel
// per valid/ready beat. Ports: clk, clr_in (async active-high reset),
// chk_in/vec_in capture, out_* beat stream, level, drop_cnt.
// Option: STAT_QUEUE_SKIP_ZERO_EN skips channels whose index is zero.
module stat_snapshot_queue
    import stat_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int VAL_W = 32,
    parameter int NUM   = 16,
    parameter int DEPTH = 4,
    parameter int CH_W  = $clog2(NUM)
) (
    input  logic                         clk,
    input  logic                         clr_in,
    input  logic                         chk_in,
    input  logic [NUM*(IDX_W+VAL_W)-1:0] vec_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_chan,
    output logic [IDX_W-1:0]             out_index,
    output logic [VAL_W-1:0]             out_value,
    output logic                         out_last,
    output logic [$clog2(DEPTH):0]       level,
    output logic [DROP_W-1:0]            drop_cnt
);

    localparam int EW = IDX_W + VAL_W;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef logic [NUM*EW-1:0] snap_t;

    snap_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, nxt_ptr;
    logic [LW-1:0] level_q, level_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    stat_state_e   state_q, state_d;

    logic             vld_q, vld_d, last_q, last_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] val_q, val_d;

    logic hs, pop, acc, more, load;
    snap_t head_vec, nxt_vec, ld_vec;
    logic [CH_W:0]   ld_start;
    logic [CH_W-1:0] ld_chan;
    logic            ld_found, ld_last;

    assign nxt_ptr  = rd_ptr_q + PW'(1);
    assign head_vec = mem_q[rd_ptr_q];
    // With a single stored snapshot the follow-on head can only be the one
    // being captured this cycle, so it is taken straight from vec_in.
    assign nxt_vec  = (level_q > LW'(1)) ? mem_q[nxt_ptr] : vec_in;

    assign hs   = vld_q & out_ready;
    // An invalid DRAIN cycle only happens for a snapshot with no beats.
    assign pop  = (state_q == DRAIN) & ((hs & last_q) | ~vld_q);
    assign acc  = chk_in & ((level_q != LW'(DEPTH)) | pop);
    assign more = (level_q > LW'(1)) | acc;

`ifdef STAT_QUEUE_SKIP_ZERO_EN
    logic [NUM*IDX_W-1:0] ld_idx;
    logic [CH_W-1:0]      hi_chan;

    always_comb begin
        ld_idx  = '0;
        hi_chan = '0;
        for (int c = 0; c < NUM; c++) begin
            ld_idx[c*IDX_W +: IDX_W] = ld_vec[c*EW+VAL_W +: IDX_W];
            if (ld_vec[c*EW+VAL_W +: IDX_W] != '0) begin
                hi_chan = CH_W'(c);
            end
        end
    end

    stat_next_chan #(
        .IDX_W (IDX_W),
        .NUM   (NUM),
        .CH_W  (CH_W)
    ) u_next (
        .idx_i   (ld_idx),
        .start_i (ld_start),
        .chan_o  (ld_chan),
        .found_o (ld_found)
    );

    assign ld_last = (ld_chan == hi_chan);
`else
    assign ld_chan  = ld_start[CH_W-1:0];
    assign ld_found = ~ld_start[CH_W];
    assign ld_last  = (ld_start[CH_W-1:0] == CH_W'(NUM - 1));
`endif

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        ld_vec   = head_vec;
        ld_start = '0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    load    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop) begin
                    if (more) begin
                        load   = 1'b1;
                        ld_vec = nxt_vec;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hs) begin
                    load     = 1'b1;
                    ld_start = {1'b0, chan_q} + (CH_W+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        chan_d = chan_q;
        idx_d  = idx_q;
        val_d  = val_q;
        if (load) begin
            vld_d  = ld_found;
            last_d = ld_found & ld_last;
            chan_d = ld_chan;
            idx_d  = ld_vec[ld_chan*EW+VAL_W +: IDX_W];
            val_d  = ld_vec[ld_chan*EW +: VAL_W];
        end else if (pop) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_comb begin
        level_d = level_q + LW'(acc) - LW'(pop);
        drop_d  = drop_q;
        if (chk_in && !acc && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr_in) begin
        if (clr_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            state_q  <= IDLE;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            chan_q   <= '0;
            idx_q    <= '0;
            val_q    <= '0;
        end else begin
            if (acc) begin
                mem_q[wr_ptr_q] <= vec_in;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= nxt_ptr;
            end
            level_q <= level_d;
            drop_q  <= drop_d;
            state_q <= state_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end

    assign out_valid = vld_q;
    assign out_last  = last_q;
    assign out_chan  = chan_q;
    assign out_index = idx_q;
    assign out_value = val_q;
    assign level     = level_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/stat_snapshot_queue.md
# stat_snapshot_queue

Parametrised snapshot queue for the statistics path. On each check strobe it captures a full vector of per-channel (index, value) counter pairs into a DEPTH-entry FIFO and drains the oldest snapshot as a serial valid/ready stream, one channel per beat, to the stat readout/host interface. It supersedes direct per-bit register capture: multiple snapshots are buffered, overflow is counted, and the consumer can apply back-pressure.

## Interface
- IDX_W, 4, index field width per channel
- VAL_W, 32, value field width per channel
- NUM, 16, channels per snapshot (≥2)
- DEPTH, 4, snapshot entries (power of 2, ≥2)
- CH_W, $clog2(NUM), channel-number width
- clk  in  1  clock; all logic on rising edge
- clr_in  in  1  reset, asynchronous, active-high; clock clk
- chk_in  in  1  capture strobe, one-cycle pulse
- vec_in  in  NUM*(IDX_W+VAL_W)  channel c at bits [(c+1)*(IDX_W+VAL_W)-1 -: IDX_W+VAL_W]; index in upper IDX_W bits, value in lower VAL_W bits
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_chan  out  CH_W  channel number of beat
- out_index  out  IDX_W  captured index
- out_value  out  VAL_W  captured value
- out_last  out  1  final beat of current snapshot
- level  out  $clog2(DEPTH)+1  snapshots stored, including the one being drained
- drop_cnt  out  16  saturating count of rejected captures

## Operation
- Reset: all storage, pointers, level=0, drop_cnt=0, out_valid=0, out_chan=0, out_last=0, out_index=0, out_value=0, FSM=IDLE.
- Capture: chk_in=1 with level<DEPTH writes vec_in to the tail entry; the tail pointer wraps modulo DEPTH.
- Capture when full: if the last beat of the head completes (out_valid & out_ready & out_last) in the same cycle, the capture is accepted into the freed slot and level is unchanged. Otherwise the capture is dropped and drop_cnt increments, saturating at 16'hFFFF.
- FSM IDLE: when level>0, go to DRAIN with the beat pointer at the first emitted channel.
- FSM DRAIN: outputs are registered from the head entry at the beat pointer. A beat transfers on out_valid & out_ready. After a non-last beat, the pointer advances to the next emitted channel. After the last beat, the head is popped and level decrements. If more snapshots remain, DRAIN restarts on the next head with no idle cycle; otherwise the FSM returns to IDLE.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Channels are emitted in ascending order, 0..NUM-1. out_last=1 only on the highest emitted channel.
- Simultaneous capture and pop are both honoured in the same cycle.
- clr_in asserted mid-drain aborts the snapshot immediately. No partial state is retained.

## Timing
- chk_in at cycle N into an empty queue: out_valid=1 at N+2, showing channel 0 of the snapshot.
- Full-rate drain: NUM beats per snapshot; back-to-back snapshots produce continuous beats.
- level updates in the cycle after the capture or pop edge.
- drop_cnt updates in the cycle after the rejected strobe.

## Configuration
- STAT_QUEUE_SKIP_ZERO_EN defined: channels whose captured index is zero are not emitted.
  - The next emitted channel is found by priority-encoder lookahead, so there are no bubbles between emitted beats.
  - out_last marks the highest channel with a non-zero index.
  - A snapshot whose indices are all zero is popped with no beat, taking one cycle in DRAIN with out_valid=0.
- Macro undefined: every channel is emitted; out_last is asserted on channel NUM-1.

## Structure
- Shared package stat_pkg holds:
  - typedef for the per-channel entry {index, value};
  - the FSM state enum (IDLE, DRAIN);
  - the drop counter width constant (16).
- Sub-module stat_next_chan: combinational search for the next emitted channel at or above a start index. It returns the channel and a found flag, and is used only when STAT_QUEUE_SKIP_ZERO_EN is defined.

## Test plan
- Single capture: NUM=16, vec_in channel c = {c[3:0], 32'hA000_0000+c}, out_ready=1 → 16 beats; chan 0..15, values A000_0000..A000_000F; out_last only on chan 15; level returns to 0.
- Back-pressure: toggle out_ready 1/0 every cycle → each beat is held stable while out_ready=0; sequence is identical to the single-capture test and completes in 32 cycles.
- Overflow: DEPTH=4, out_ready=0, 6 strobes → level=4, drop_cnt=2; releasing out_ready drains exactly the first 4 snapshots in order.
- Full plus pop collision: queue full; chk_in pulsed on the cycle of the last-beat handshake → capture accepted, drop_cnt unchanged, level stays 4.
- Skip-zero (macro defined): indices nonzero only on channels 3 and 9 → 2 beats, chan 3 then chan 9 with out_last. An all-zero snapshot produces no beat and level decrements.
- Reset mid-drain: assert clr_in at beat 5 → out_valid=0, level=0, drop_cnt=0 immediately; the next capture starts again from channel 0.
